// File: rtl/peri_wb_bridge_if.sv
// Bus bundle between a Wishbone master, the bridge and the peripheral register bus.
// The bridge takes the slave view; the environment (master + register target) takes the master view.
interface peri_wb_bridge_if #(
    parameter int AW = 11
);
    logic          wbs_cyc_i;
    logic          wbs_stb_i;
    logic          wbs_we_i;
    logic [AW-1:0] wbs_adr_i;
    logic [31:0]   wbs_dat_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic          wbs_err_o;

    logic          reg_cs;
    logic          reg_wr;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wdata;
    logic [3:0]    reg_be;
    logic [31:0]   reg_rdata;
    logic          reg_ack;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/peri_wb_bridge.sv
// Wishbone slave to peripheral register-bus bridge with an access watchdog.
// Handshake: a request is taken when cyc&stb are sampled high in IDLE; it ends when reg_ack is sampled high or the watchdog expires, answered by a one-cycle ack or err.
module peri_wb_bridge #(
    parameter int          AW        = 11,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                mclk,
    input  logic                s_reset_n,
    peri_wb_bridge_if.slave     bus,
    input  logic                timeout_clr,
    output logic                timeout_flag,
    output logic [1:0]          fsm_state
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          aborted;
    logic          suppress;
    logic          expired;
    logic          set_flag;

    // Once the master has let go of cyc, the response is swallowed.
    assign suppress  = aborted | ~bus.wbs_cyc_i;
    assign expired   = (cnt == CW'(TIMEOUT - 1));
    assign set_flag  = (state == ACCESS) && !bus.reg_ack && expired;
    assign fsm_state = state;

    always_ff @(posedge mclk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            aborted       <= 1'b0;
            bus.reg_cs    <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_be    <= '0;
            bus.wbs_dat_o <= '0;
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_err_o <= 1'b0;
        end else begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wbs_cyc_i && bus.wbs_stb_i) begin
                        bus.reg_cs    <= 1'b1;
                        bus.reg_wr    <= bus.wbs_we_i;
                        bus.reg_addr  <= bus.wbs_adr_i;
                        bus.reg_wdata <= bus.wbs_dat_i;
                        bus.reg_be    <= bus.wbs_sel_i;
                        cnt           <= '0;
                        aborted       <= 1'b0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!bus.wbs_cyc_i) begin
                        aborted <= 1'b1;
                    end
                    // An ack arriving on the last watchdog cycle still counts as a normal completion.
                    if (bus.reg_ack) begin
                        bus.reg_cs    <= 1'b0;
                        bus.wbs_ack_o <= ~suppress;
                        bus.wbs_dat_o <= bus.reg_wr ? 32'h0 : bus.reg_rdata;
                        state         <= RESP;
                    end else if (expired) begin
                        bus.reg_cs    <= 1'b0;
                        bus.wbs_err_o <= ~suppress;
                        bus.wbs_dat_o <= bus.reg_wr ? 32'h0 : ERR_RDATA;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A timeout in the same cycle as a clear request wins.
    always_ff @(posedge mclk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            timeout_flag <= 1'b0;
        end else if (set_flag) begin
            timeout_flag <= 1'b1;
        end else if (timeout_clr) begin
            timeout_flag <= 1'b0;
        end
    end
endmodule

// File: doc/peri_wb_bridge.md
Name: peri_wb_bridge

Overview:
Wishbone-slave to peripheral register-bus bridge. It sits directly upstream of the peripheral top and drives its reg_cs/reg_wr/reg_addr/reg_wdata/reg_be request bus. It waits for reg_ack, then returns read data and a single-cycle ack to the Wishbone master. A watchdog terminates any access that no sub-block acknowledges and reports it as a bus error.

Parameters:
AW, 11, register address width (matches peripheral reg_addr)
TIMEOUT, 255, max cycles reg_cs is held waiting for reg_ack (legal range 2..65535)
ERR_RDATA, 32'hDEAD_BEEF, value returned on wbs_dat_o for a timed-out read

Ports:
mclk  in  1  system clock
s_reset_n  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  1 = write
wbs_adr_i  in  AW  register address
wbs_dat_i  in  32  write data
wbs_sel_i  in  4  byte enables
wbs_dat_o  out  32  read data
wbs_ack_o  out  1  transfer done, one cycle
wbs_err_o  out  1  transfer timed out, one cycle
reg_cs  out  1  register bus chip select
reg_wr  out  1  register bus write
reg_addr  out  AW  register bus address
reg_wdata  out  32  register bus write data
reg_be  out  4  register bus byte enables
reg_rdata  in  32  register bus read data
reg_ack  in  1  register bus acknowledge
timeout_clr  in  1  clears timeout_flag
timeout_flag  out  1  sticky: at least one timeout has occurred

Behaviour:
- Reset (asynchronous, s_reset_n=0): all outputs 0, state IDLE, counter 0, timeout_flag 0. A reset in the middle of an access aborts it with no ack or err.
- All outputs are registered. There are no combinational paths from input to output.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i sampled at edge T: latch we/adr/dat/sel onto reg_wr/reg_addr/reg_wdata/reg_be.
  - reg_cs=1 from T+1. Counter cleared. Go to ACCESS.
- ACCESS:
  - reg_cs and the reg_* request fields are held stable.
  - The counter increments each cycle.
  - reg_ack=1 at edge A:
    - reg_cs=0 from A+1.
    - wbs_ack_o=1 for exactly cycle A+1.
    - wbs_dat_o = reg_rdata for a read, 0 for a write.
    - Go to RESP.
  - Timeout: no reg_ack after reg_cs has been high TIMEOUT cycles (counter reaches TIMEOUT-1 without ack):
    - reg_cs drops.
    - wbs_err_o=1 for one cycle.
    - wbs_dat_o = ERR_RDATA for a read, 0 for a write.
    - timeout_flag set. Go to RESP.
  - reg_ack in the same cycle as the timeout condition: ack wins, no err, flag unchanged.
  - Master abort (wbs_cyc_i dropped while in ACCESS): the access completes or times out normally, but wbs_ack_o/wbs_err_o are suppressed. timeout_flag is still set on a timeout.
- RESP:
  - Lasts one cycle. wbs_ack_o/wbs_err_o return to 0. Go to IDLE.
  - A stb still high in RESP is not sampled as a new request. Back-to-back accesses therefore start 3+ cycles apart.
- wbs_dat_o holds its last value until the next completion.
- reg_ack seen in IDLE or RESP is ignored.
- reg_rdata is sampled only in the reg_ack cycle.
- timeout_flag:
  - A set in the same cycle as timeout_clr takes priority (flag ends at 1).
  - Otherwise timeout_clr=1 clears the flag the following cycle.
- Counter width: $clog2(TIMEOUT+1). No wrap-around is possible.
- Minimum latency: stb sample -> wbs_ack_o = 2 cycles when reg_ack returns in the first reg_cs cycle.

Test Plan:
- Write adr=0x080, dat=0x1234_5678, sel=0xF; slave acks after 1 cycle -> reg_cs high 1 cycle with reg_wr=1 and fields matching; wbs_ack_o pulses 1 cycle; wbs_err_o=0.
- Read adr=0x085; slave returns reg_rdata=0xA5A5_0001 after 3 cycles -> wbs_dat_o=0xA5A5_0001 with a 1-cycle wbs_ack_o exactly 1 cycle after reg_ack.
- Read with no slave ack, TIMEOUT=255 -> reg_cs high exactly 255 cycles, then wbs_err_o 1 cycle, wbs_dat_o=0xDEAD_BEEF, timeout_flag=1; timeout_clr then clears the flag.
- reg_ack on the final timeout cycle -> wbs_ack_o (not err), timeout_flag stays 0. Repeat with timeout_clr asserted on a timeout cycle -> flag=1.
- Master drops wbs_cyc_i mid-ACCESS; slave acks later -> reg_cs drops, no wbs_ack_o; the next request is accepted normally.
- Assert s_reset_n=0 asynchronously mid-ACCESS -> all outputs 0 immediately; after release, the next read completes normally.
